// File: rtl/card_datapath_if.sv
// Signal bundle between the baccarat dealing state machine (master) and the card datapath (slave).
interface card_datapath_if;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       dbg_card_en;
  logic [3:0] dbg_card;
  logic [3:0] pcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [2:0] cards_dealt;
  logic       load_error;
  logic [6:0] HEX5;
  logic [6:0] HEX4;
  logic [6:0] HEX3;
  logic [6:0] HEX2;
  logic [6:0] HEX1;
  logic [6:0] HEX0;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output dbg_card_en, dbg_card,
    input  pcard3, pscore, dscore, cards_dealt, load_error,
    input  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  dbg_card_en, dbg_card,
    output pcard3, pscore, dscore, cards_dealt, load_error,
    output HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
  );
endinterface

// File: rtl/card_datapath.sv
// Baccarat card datapath: dealer counter, six card slots, hand scores, fill count,
// illegal-load detection and 7-segment card displays.
module card_datapath #(
  parameter int unsigned DEAL_START     = 1,
  parameter bit          HEX_ACTIVE_LOW = 1'b1
) (
  input logic            slow_clock,
  input logic            reset,
  card_datapath_if.slave bus
);
  localparam logic [3:0] CTR_INIT = 4'(DEAL_START);

  logic [3:0]      deal_ctr;
  logic [5:0][3:0] slot;        // [0..2] player cards 1..3, [3..5] dealer cards 1..3
  logic [5:0]      load;
  logic [5:0]      filled;
  logic [5:0]      load_new;
  logic [3:0]      dealt;
  logic [2:0]      cards_dealt;
  logic            load_error;
  logic [2:0]      n_load;
  logic [2:0]      n_new;
  logic [3:0]      next_count;
  logic            multi_load;
  logic            overwrite;
  logic            early_third;

  function automatic logic [3:0] legal_card(input logic [3:0] c);
    return (c == 4'd0 || c > 4'd13) ? 4'd13 : c;
  endfunction

  function automatic logic [4:0] card_value(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  // Sum of three values is at most 27, so two conditional subtractions give mod 10.
  function automatic logic [3:0] hand_score(input logic [3:0] c1, input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] s;
    s = card_value(c1) + card_value(c2) + card_value(c3);
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd1:    s = 7'h77;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd10:   s = 7'h3F;
      4'd11:   s = 7'h1E;
      4'd12:   s = 7'h67;
      4'd13:   s = 7'h76;
      default: s = 7'h00;
    endcase
    return HEX_ACTIVE_LOW ? ~s : s;
  endfunction

  assign load = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                 bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  always_comb begin
    filled = '0;
    for (int i = 0; i < 6; i++) filled[i] = (slot[i] != 4'd0);
  end

  assign dealt       = bus.dbg_card_en ? legal_card(bus.dbg_card) : deal_ctr;
  assign load_new    = load & ~filled;
  assign n_load      = popcount6(load);
  assign n_new       = popcount6(load_new);
  assign next_count  = {1'b0, cards_dealt} + {1'b0, n_new};
  assign multi_load  = (n_load > 3'd1);
  assign overwrite   = |(load & filled);
  assign early_third = (load[2] & ~(filled[0] & filled[1])) |
                       (load[5] & ~(filled[3] & filled[4]));

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      deal_ctr    <= CTR_INIT;
      slot        <= '0;
      cards_dealt <= '0;
      load_error  <= 1'b0;
    end else begin
      deal_ctr <= (deal_ctr >= 4'd13) ? 4'd1 : deal_ctr + 4'd1;
      for (int i = 0; i < 6; i++) begin
        if (load[i]) slot[i] <= dealt;
      end
      cards_dealt <= (next_count > 4'd6) ? 3'd6 : next_count[2:0];
      if (multi_load | overwrite | early_third) load_error <= 1'b1;
    end
  end

  assign bus.pcard3      = slot[2];
  assign bus.pscore      = hand_score(slot[0], slot[1], slot[2]);
  assign bus.dscore      = hand_score(slot[3], slot[4], slot[5]);
  assign bus.cards_dealt = cards_dealt;
  assign bus.load_error  = load_error;
  assign bus.HEX5        = seg7(slot[0]);
  assign bus.HEX4        = seg7(slot[1]);
  assign bus.HEX3        = seg7(slot[2]);
  assign bus.HEX2        = seg7(slot[3]);
  assign bus.HEX1        = seg7(slot[4]);
  assign bus.HEX0        = seg7(slot[5]);
endmodule

// File: tb/tb_card_datapath.sv
// Scoreboard bench for card_datapath: random and directed strobes against a behavioural hand model.
module tb_card_datapath;
  localparam int DEAL_START = 1;

  logic slow_clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  card_datapath_if bus ();

  card_datapath #(.DEAL_START(DEAL_START), .HEX_ACTIVE_LOW(1'b1)) dut (
    .slow_clock(slow_clock),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct packed {
    logic [3:0]      pcard3;
    logic [3:0]      pscore;
    logic [3:0]      dscore;
    logic [2:0]      cards_dealt;
    logic            load_error;
    logic [5:0][6:0] hex;        // hex[i] is HEXi
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Active-high segment patterns {g,f,e,d,c,b,a} for card codes 0..13.
  logic [6:0] seg_table [14] = '{7'h00, 7'h77, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                 7'h07, 7'h7F, 7'h6F, 7'h3F, 7'h1E, 7'h67, 7'h76};

  // Model state: hand slots, edges since reset release, fill count, error flag.
  int slots [6];
  int edges;
  int filled_cnt;
  bit err_flag;

  function automatic int points(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic exp_t build_expect();
    exp_t e;
    e.pcard3      = 4'(slots[2]);
    e.pscore      = 4'((points(slots[0]) + points(slots[1]) + points(slots[2])) % 10);
    e.dscore      = 4'((points(slots[3]) + points(slots[4]) + points(slots[5])) % 10);
    e.cards_dealt = 3'(filled_cnt);
    e.load_error  = err_flag;
    for (int i = 0; i < 6; i++) e.hex[i] = ~seg_table[slots[5 - i]];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the coming edge, queue the expectation.
  task automatic step(input bit rst, input logic [5:0] ld, input bit en, input logic [3:0] dc);
    int card;
    int nld;
    @(negedge slow_clock);
    reset = rst;
    {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = ld;
    bus.dbg_card_en = en;
    bus.dbg_card    = dc;
    if (rst) begin
      for (int i = 0; i < 6; i++) slots[i] = 0;
      edges = 0; filled_cnt = 0; err_flag = 0;
    end else begin
      if (en) card = (dc == 0 || dc > 13) ? 13 : int'(dc);
      else    card = ((DEAL_START - 1 + edges) % 13) + 1;
      nld = 0;
      for (int i = 0; i < 6; i++) if (ld[i]) nld++;
      if (nld > 1) err_flag = 1;
      if (ld[2] && (slots[0] == 0 || slots[1] == 0)) err_flag = 1;
      if (ld[5] && (slots[3] == 0 || slots[4] == 0)) err_flag = 1;
      for (int i = 0; i < 6; i++) begin
        if (ld[i]) begin
          if (slots[i] != 0) err_flag = 1;
          else               filled_cnt++;
          slots[i] = card;
        end
      end
      if (filled_cnt > 6) filled_cnt = 6;
      edges++;
    end
    sb.push_back(build_expect());
  endtask

  task automatic settle();
    @(posedge slow_clock);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge slow_clock);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("pcard3",      32'(bus.pcard3),      32'(mon_e.pcard3));
        check("pscore",      32'(bus.pscore),      32'(mon_e.pscore));
        check("dscore",      32'(bus.dscore),      32'(mon_e.dscore));
        check("cards_dealt", 32'(bus.cards_dealt), 32'(mon_e.cards_dealt));
        check("load_error",  32'(bus.load_error),  32'(mon_e.load_error));
        check("hex", 32'({bus.HEX5, bus.HEX4, bus.HEX3}), 32'({mon_e.hex[5], mon_e.hex[4], mon_e.hex[3]}));
        check("hex_d", 32'({bus.HEX2, bus.HEX1, bus.HEX0}), 32'({mon_e.hex[2], mon_e.hex[1], mon_e.hex[0]}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ld;
    int r;
    reset = 1'b1;
    {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = '0;
    bus.dbg_card_en = 1'b0;
    bus.dbg_card    = 4'd0;

    step(1, 6'b0, 0, 0);
    step(1, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    settle();
    check("reset_cards_dealt", 32'(bus.cards_dealt), 0);
    check("reset_hex0", 32'(bus.HEX0), 32'h7F);

    // Dealer counter run, then reset mid-load: outputs clear before any edge.
    step(0, 6'b000001, 0, 0);
    step(0, 6'b001000, 0, 0);
    step(1, 6'b000010, 1, 5);
    #1;
    check("async_cards_dealt", 32'(bus.cards_dealt), 0);
    check("async_hex5", 32'(bus.HEX5), 32'h7F);
    check("async_pscore", 32'(bus.pscore), 0);

    // Player 3 + 6 = 9.
    step(0, 6'b000001, 1, 3);
    step(0, 6'b000010, 1, 6);
    settle();
    check("t2_pscore", 32'(bus.pscore), 9);
    check("t2_cards_dealt", 32'(bus.cards_dealt), 2);

    // Dealer Q, K, 7 -> 7.
    step(0, 6'b001000, 1, 12);
    step(0, 6'b010000, 1, 13);
    step(0, 6'b100000, 1, 7);
    settle();
    check("t3_dscore", 32'(bus.dscore), 7);
    check("t3_hex0", 32'(bus.HEX0), 32'h78);
    check("t3_hex2", 32'(bus.HEX2), 32'h18);
    check("t3_load_error", 32'(bus.load_error), 0);

    // Counter wrap: 13th edge deals K, 14th deals A.
    step(1, 6'b0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 6'b0, 0, 0);
    step(0, 6'b000001, 0, 0);
    step(0, 6'b000010, 0, 0);
    settle();
    check("t4_hex5", 32'(bus.HEX5), 32'h09);
    check("t4_hex4", 32'(bus.HEX4), 32'h08);
    check("t4_pscore", 32'(bus.pscore), 1);

    // Simultaneous strobes: both load, error sticks until reset.
    step(1, 6'b0, 0, 0);
    step(0, 6'b001001, 1, 5);
    settle();
    check("t5_hex5", 32'(bus.HEX5), 32'h12);
    check("t5_hex2", 32'(bus.HEX2), 32'h12);
    check("t5_cards_dealt", 32'(bus.cards_dealt), 2);
    check("t5_load_error", 32'(bus.load_error), 1);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    settle();
    check("t5_sticky", 32'(bus.load_error), 1);
    step(1, 6'b0, 0, 0);
    #1;
    check("t5_cleared", 32'(bus.load_error), 0);

    // Early third card, then overwrite of the same slot.
    step(0, 6'b000100, 1, 4);
    settle();
    check("t6_pcard3", 32'(bus.pcard3), 4);
    check("t6_load_error", 32'(bus.load_error), 1);
    step(0, 6'b000100, 1, 9);
    settle();
    check("t6_pcard3_reload", 32'(bus.pcard3), 9);
    check("t6_cards_dealt", 32'(bus.cards_dealt), 1);

    // Out-of-range debug cards read as K.
    step(1, 6'b0, 0, 0);
    step(0, 6'b000001, 1, 0);
    step(0, 6'b000010, 1, 15);
    settle();
    check("dbg_bad_hex5", 32'(bus.HEX5), 32'h09);
    check("dbg_bad_hex4", 32'(bus.HEX4), 32'h09);
    check("dbg_bad_pscore", 32'(bus.pscore), 0);

    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      ld = 6'b0;
      else if (r < 8) ld = 6'b000001 << $urandom_range(0, 5);
      else            ld = 6'($urandom);
      step($urandom_range(0, 99) < 6, ld, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge slow_clock);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
